// File: rtl/instruction_fetch_unit.sv
// Generic synchronous FIFO: head is read combinationally from storage; 0-cycle read, 1-cycle write.
// No internal backpressure: caller must never push when full without a same-cycle pop.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (!(push && !pop && count == CW'(DEPTH)));
  end
endmodule

// Fetch front end: issues word reads to a 1-cycle RAM, queues {instr, pc}; first instr 2 cycles after issue.
// Issue stalls once queued + in-flight reaches DEPTH; redirect flushes queue and in-flight reads.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_rw,
  input  logic [31:0]           mem_dout,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] s1_pc;
  logic [ADDR_WIDTH-1:0] s2_pc;
  logic                  s1_vld;
  logic                  s2_vld;
  logic                  issue;
  logic                  pop;
  logic [CW-1:0]         count;
  logic [OW-1:0]         occ;
  entry_t                push_ent;
  entry_t                head_ent;

  assign mem_rw = 1'b0;

  // Same-cycle pop is not credited, so issue never depends on instr_ready.
  assign occ   = OW'(count) + OW'(s1_vld) + OW'(s2_vld);
  assign issue = occ < OW'(DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      mem_a  <= RESET_PC;
      s1_vld <= 1'b0;
      s1_pc  <= '0;
      s2_vld <= 1'b0;
      s2_pc  <= '0;
    end else begin
      s2_pc  <= s1_pc;
      s2_vld <= s1_vld & ~redirect;
      if (redirect) begin
        mem_a  <= redirect_pc;
        s1_vld <= 1'b1;
        s1_pc  <= redirect_pc;
        pc_q   <= redirect_pc + ADDR_WIDTH'(1);
      end else if (issue) begin
        mem_a  <= pc_q;
        s1_vld <= 1'b1;
        s1_pc  <= pc_q;
        pc_q   <= pc_q + ADDR_WIDTH'(1);
      end else begin
        s1_vld <= 1'b0;
      end
    end
  end

  assign push_ent = '{instr: mem_dout, pc: s2_pc};

  fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push     (s2_vld),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .count    (count)
  );

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  assign instr       = instr_valid ? head_ent.instr : '0;
  assign instr_pc    = instr_valid ? head_ent.pc : '0;
endmodule
